overflow_reporter: RTL and testbench
====================================

# overflow_reporter

Collects the per-channel `oflow_state` flags produced by the overflow detectors and reports them to the host over a valid/ready word stream. After a report has been fully accepted, the block drives the detectors' `oflow_Clr` input so that the reported overflows are cleared. It sits between the overflow detector bank and the readout/command path. It is the consumer side of the detector's `oflow_in`/`oflow_Clr`/`oflow_state` contract.

## Interface
Parameters:
- `N_CH`, 8: number of detector channels, 1..16.
- `CLR_CYCLES`, 2: length of the `oflow_Clr` pulse in clocks, 1..15.

Ports:
- `clk` in 1: system clock; everything is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `oflow_state` in N_CH: level flags from the detectors; bit i belongs to channel i.
- `rd_req` in 1: single-cycle report request. Ignored while `busy`=1.
- `out_ready` in 1: downstream accepts the current word.
- `out_valid` out 1: `out_data` holds a valid word.
- `out_data` out 16: report word.
- `out_last` out 1: high with the final word of the report.
- `oflow_Clr` out 1: clear strobe to the detectors; wire it to every channel.
- `busy` out 1: high while a report or clear is in progress.

## Operation
- Sticky register `stk[N_CH-1:0]`: each cycle `stk |= oflow_state`. Exception: no update in the CLEAR state.
- FSM states: IDLE, SNAP, SEND, CLEAR.
- IDLE -> SNAP on `rd_req`=1.
- SNAP captures `snap <= stk | oflow_state`, then moves to SEND.
- SEND emits the report words in order:
  - w0 = {8'hA5, 8'(N_CH)}.
  - w1 = snap zero-extended to 16 bits.
  - With counters enabled: w2..w(N_CH+1) = {8'(i), cnt_snap[i]} for i = 0..N_CH-1.
- A word advances only when `out_valid && out_ready`. After the handshake on the word with `out_last`=1, the FSM moves to CLEAR.
- CLEAR holds `oflow_Clr`=1 for exactly CLR_CYCLES cycles.
  - On entry, clear the bits of `stk` that were set in `snap`. Bits set after SNAP are kept.
  - Then return to IDLE.
- `busy` = 1 in SNAP, SEND and CLEAR.
- `rd_req` outside IDLE is dropped, not queued.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `oflow_Clr`=0, `busy`=0. `stk`, `snap` and all counters are 0. FSM is in IDLE.
- Assertion of `rst_n` in any state aborts immediately. An in-flight report is lost and no clear is issued.
- `rd_req` sampled high in IDLE at edge t: SNAP at t+1, and `out_valid`=1 with w0 from t+2.
- Zero-wait streaming: one word per cycle when `out_ready` is held at 1.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- `out_valid` drops in the cycle after the last handshake. `oflow_Clr` rises in that same cycle.
- `oflow_Clr` is registered and glitch-free. IDLE is re-entered CLR_CYCLES cycles after `oflow_Clr` rises.
- Channel rising in the same cycle as SNAP: it is captured in `snap`.
- Channel rising during SEND: it is set in `stk`, survives the clear, and appears in the next report.

## Configuration
- `OFLOW_COUNT_EN` defined:
  - Per-channel 8-bit event counters `cnt[i]` increment on each 0->1 transition of `oflow_state[i]`, detected against a registered copy of `oflow_state`.
  - Counters saturate at 255.
  - Counters are frozen in CLEAR. `cnt_snap` is taken in SNAP.
  - On CLEAR entry, `cnt[i]` is zeroed for every channel with `snap[i]`=1.
  - The report is N_CH+2 words long.
- `OFLOW_COUNT_EN` undefined:
  - No counters and no edge registers.
  - The report is 2 words; `out_last` is set on w1.

## Test plan
- Reset check: reset, then `rd_req` with all flags 0 and `out_ready`=1 -> words 16'hA508, 16'h0000. `out_last` on the final word, then `oflow_Clr` high for 2 cycles, `busy` low 3 cycles after the last handshake.
- Sticky capture: pulse `oflow_state[3]` for 1 cycle, wait 10 cycles, `rd_req` -> w1 = 16'h0008. A second report after the clear gives w1 = 16'h0000.
- Late event during SEND: with `out_ready`=0 for 5 cycles in SEND, raise `oflow_state[5]` -> current w1 excludes bit 5; the next report's w1 = 16'h0020.
- Backpressure: toggle `out_ready` 0/1 every cycle -> no word is dropped or duplicated, and `out_data` is stable while stalled.
- Busy and reset: `rd_req` pulsed in SEND -> ignored, only one report produced. `rst_n` low mid-SEND -> all outputs 0, `oflow_Clr` never asserted.
- Counters (`OFLOW_COUNT_EN`): 300 rising edges on channel 2 -> word w4 = 16'h02FF, and channel 2's counter reads 0 in the next report.

Source files
------------

// File: rtl/overflow_reporter.sv
// Snapshots the sticky detector overflow flags, streams them as a valid/ready report,
// then pulses oflow_Clr. Per-channel rise counters are added when OFLOW_COUNT_EN is defined.
module overflow_reporter #(
    parameter int N_CH       = 8,
    parameter int CLR_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] oflow_state,
    input  logic            rd_req,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [15:0]     out_data,
    output logic            out_last,
    output logic            oflow_Clr,
    output logic            busy
);

`ifdef OFLOW_COUNT_EN
    localparam int N_WORDS = N_CH + 2;
`else
    localparam int N_WORDS = 2;
`endif
    localparam logic [4:0] LAST_IDX = 5'(N_WORDS - 1);
    localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNAP  = 2'd1,
        ST_SEND  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [N_CH-1:0]      stk_q, stk_d;
    logic [N_CH-1:0]      snap_q, snap_d;
    logic [4:0]           idx_q, idx_d;
    logic [3:0]           clr_cnt_q, clr_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [15:0]          out_data_q, out_data_d;
    logic                 clr_q, clr_d;
    logic                 busy_q, busy_d;
    logic                 hs_s;
    logic                 clr_entry_s;
    logic [N_CH-1:0][7:0] cnt_snap_s;

    function automatic logic [15:0] word_at(input logic [4:0]           k,
                                            input logic [N_CH-1:0]      snap,
                                            input logic [N_CH-1:0][7:0] cs);
        logic [15:0] w;
        w = 16'h0000;
        if (k == 5'd0) begin
            w = {8'hA5, 8'(N_CH)};
        end else if (k == 5'd1) begin
            w = 16'(snap);
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (k == 5'(i + 2)) begin
                    w = {8'(i), cs[i]};
                end else begin
                    w = w;
                end
            end
        end
        return w;
    endfunction

    assign hs_s        = out_valid_q && out_ready;
    assign clr_entry_s = (state_q == ST_SEND) && hs_s && out_last_q;

`ifdef OFLOW_COUNT_EN
    logic [N_CH-1:0][7:0] cnt_q, cnt_d;
    logic [N_CH-1:0][7:0] cnt_snap_q, cnt_snap_d;
    logic [N_CH-1:0]      prev_q;

    // Rise counters: saturate at 255, frozen in CLEAR, reported channels zeroed on CLEAR entry.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_CH; i++) begin
            if (state_q == ST_CLEAR) begin
                cnt_d[i] = cnt_q[i];
            end else if (clr_entry_s && snap_q[i]) begin
                cnt_d[i] = 8'h00;
            end else if (oflow_state[i] && !prev_q[i] && (cnt_q[i] != 8'hFF)) begin
                cnt_d[i] = cnt_q[i] + 8'h01;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
        if (state_q == ST_SNAP) begin
            cnt_snap_d = cnt_d;
        end else begin
            cnt_snap_d = cnt_snap_q;
        end
    end

    // Counter, counter snapshot and edge-reference registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            cnt_snap_q <= '0;
            prev_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            cnt_snap_q <= cnt_snap_d;
            prev_q     <= oflow_state;
        end
    end

    assign cnt_snap_s = cnt_snap_q;
`else
    assign cnt_snap_s = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; requests outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) state_d = ST_SNAP;
                else        state_d = ST_IDLE;
            end
            ST_SNAP: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (hs_s && out_last_q) state_d = ST_CLEAR;
                else                    state_d = ST_SEND;
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) state_d = ST_IDLE;
                else                       state_d = ST_CLEAR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        stk_d       = stk_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        clr_cnt_d   = 4'd0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        // Bits raised after the snapshot survive the clear.
        if (state_q == ST_CLEAR) begin
            stk_d     = stk_q;
            clr_cnt_d = clr_cnt_q + 4'd1;
        end else if (clr_entry_s) begin
            stk_d = (stk_q | oflow_state) & ~snap_q;
        end else begin
            stk_d = stk_q | oflow_state;
        end

        case (state_q)
            ST_SNAP: begin
                snap_d      = stk_q | oflow_state;
                idx_d       = 5'd0;
                out_valid_d = 1'b1;
                out_data_d  = word_at(5'd0, snap_q, cnt_snap_s);
                out_last_d  = (LAST_IDX == 5'd0);
            end
            ST_SEND: begin
                if (hs_s && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_data_d  = 16'h0000;
                    out_last_d  = 1'b0;
                end else if (hs_s) begin
                    idx_d      = idx_q + 5'd1;
                    out_data_d = word_at(idx_q + 5'd1, snap_q, cnt_snap_s);
                    out_last_d = ((idx_q + 5'd1) == LAST_IDX);
                end else begin
                    out_data_d = out_data_q;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                out_data_d  = 16'h0000;
                out_last_d  = 1'b0;
            end
        endcase

        clr_d  = (state_d == ST_CLEAR);
        busy_d = (state_d != ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_q       <= '0;
            snap_q      <= '0;
            idx_q       <= 5'd0;
            clr_cnt_q   <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            out_last_q  <= 1'b0;
            clr_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            stk_q       <= stk_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            clr_cnt_q   <= clr_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            clr_q       <= clr_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign oflow_Clr = clr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_overflow_reporter.sv
// Randomised self-checking bench for overflow_reporter against a set/count reference model.
module tb_overflow_reporter;
    localparam int N_CH = 8;
`ifdef OFLOW_COUNT_EN
    localparam int N_WORDS = N_CH + 2;
`else
    localparam int N_WORDS = 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_CH-1:0]   oflow_state;
    logic              rd_req;
    logic              out_ready;
    logic              out_valid;
    logic [15:0]       out_data;
    logic              out_last;
    logic              oflow_Clr;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: set of flagged channels and per-channel rise counts.
    logic [N_CH-1:0] m_stk, m_prev, m_snap;
    int              m_cnt[N_CH];
    int              m_cnt_snap[N_CH];

    logic [15:0] got_w[$];
    logic        got_l[$];
    int          first_valid_cyc, loop_cycles, unstable;
    bit          timed_out;
    logic        snap_busy, snap_valid;
    logic        post_valid[4], post_clr[4], post_busy[4];

    overflow_reporter #(.N_CH(N_CH), .CLR_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .oflow_state(oflow_state), .rd_req(rd_req),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .oflow_Clr(oflow_Clr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_stk = '0; m_prev = '0; m_snap = '0;
        for (int i = 0; i < N_CH; i++) begin m_cnt[i] = 0; m_cnt_snap[i] = 0; end
    endtask

    // Drive one clock of inputs (called at a negedge) and account for it in the model.
    task automatic drive_cycle(input logic [N_CH-1:0] st, input logic req, input logic rdy);
        oflow_state = st; rd_req = req; out_ready = rdy;
        m_stk = m_stk | st;
        for (int i = 0; i < N_CH; i++) if (st[i] && !m_prev[i]) m_cnt[i]++;
        m_prev = st;
        @(negedge clk);
    endtask

    function automatic logic [15:0] exp_word(input int k);
        if (k == 0) return {8'hA5, 8'(N_CH)};
        if (k == 1) return 16'(m_snap);
        return {8'(k - 2), 8'((m_cnt_snap[k-2] > 255) ? 255 : m_cnt_snap[k-2])};
    endfunction

    // Request one report and collect it. mode: 0 ready=1, 1 toggle, 2 random, 3 stall 5 then ready.
    task automatic run_report(input int mode, input logic [N_CH-1:0] snap_st, input int late_at,
                              input logic [N_CH-1:0] late_st, input int req_at);
        logic v, l, rdy, hs, stalled;
        logic [15:0] d, prev_d;
        got_w.delete(); got_l.delete();
        first_valid_cyc = -1; unstable = 0; timed_out = 1'b1; stalled = 1'b0; prev_d = 16'h0000;
        loop_cycles = 0;
        drive_cycle('0, 1'b1, 1'b0);
        snap_busy = busy; snap_valid = out_valid;
        drive_cycle(snap_st, 1'b0, 1'b0);
        m_snap = m_stk;
        for (int i = 0; i < N_CH; i++) m_cnt_snap[i] = m_cnt[i];
        for (int cyc = 0; cyc < 200; cyc++) begin
            v = out_valid; d = out_data; l = out_last;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 2) == 1);
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc >= 5);
            endcase
            if (v && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stalled && (d !== prev_d)) unstable++;
            stalled = v && !rdy; prev_d = d;
            hs = v && rdy;
            drive_cycle((cyc == late_at) ? late_st : '0, (cyc == req_at), rdy);
            if (hs) begin got_w.push_back(d); got_l.push_back(l); end
            if (hs && l) begin timed_out = 1'b0; loop_cycles = cyc + 1; break; end
        end
        for (int k = 0; k < 4; k++) begin
            post_valid[k] = out_valid; post_clr[k] = oflow_Clr; post_busy[k] = busy;
            drive_cycle('0, 1'b0, 1'b0);
        end
        m_stk = m_stk & ~m_snap;
        for (int i = 0; i < N_CH; i++) if (m_snap[i]) m_cnt[i] = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; oflow_state = '0; rd_req = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, out_last, oflow_Clr, busy} !== 4'b0000 || out_data !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%b last=%b clr=%b busy=%b data=%h, expected all 0",
                     out_valid, out_last, oflow_Clr, busy, out_data);
        end
        rst_n = 1'b1; model_reset();
        @(negedge clk);
        run_report(0, '0, -1, '0, -1);
        n_checks++; if (timed_out !== 1'b0) begin n_errors++; $display("FAIL reset_timeout: got 1 expected 0"); end
        n_checks++; if (snap_busy !== 1'b1) begin n_errors++; $display("FAIL reset_busy_snap: got %b expected 1", snap_busy); end
        n_checks++; if (snap_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid_snap: got %b expected 0", snap_valid); end
        n_checks++; if (first_valid_cyc !== 0) begin n_errors++; $display("FAIL reset_latency: got %0d expected 0", first_valid_cyc); end
        n_checks++; if (loop_cycles !== N_WORDS) begin n_errors++; $display("FAIL reset_zero_wait: got %0d cycles expected %0d", loop_cycles, N_WORDS); end
        n_checks++; if (got_w.size() !== N_WORDS) begin n_errors++; $display("FAIL reset_len: got %0d expected %0d", got_w.size(), N_WORDS); end
        n_checks++; if (got_w[0] !== 16'hA508) begin n_errors++; $display("FAIL reset_w0: got %h expected a508", got_w[0]); end
        n_checks++; if (got_w[1] !== 16'h0000) begin n_errors++; $display("FAIL reset_w1: got %h expected 0000", got_w[1]); end
        for (int k = 0; k < got_w.size(); k++) begin
            n_checks++;
            if (got_l[k] !== (k == N_WORDS - 1)) begin n_errors++; $display("FAIL reset_last[%0d]: got %b", k, got_l[k]); end
        end
        n_checks++; if (post_valid[0] !== 1'b0) begin n_errors++; $display("FAIL reset_valid_drop: got %b expected 0", post_valid[0]); end
        n_checks++;
        if ({post_clr[0], post_clr[1], post_clr[2]} !== 3'b110) begin
            n_errors++; $display("FAIL reset_clr_pulse: got %b%b%b expected 110", post_clr[0], post_clr[1], post_clr[2]);
        end
        n_checks++;
        if ({post_busy[0], post_busy[1], post_busy[2]} !== 3'b110) begin
            n_errors++; $display("FAIL reset_busy_tail: got %b%b%b expected 110", post_busy[0], post_busy[1], post_busy[2]);
        end
    endtask

    task automatic test_sticky();
        drive_cycle(8'h08, 1'b0, 1'b0);
        repeat (10) drive_cycle('0, 1'b0, 1'b0);
        run_report(0, '0, -1, '0, -1);
        n_checks++; if (got_w[1] !== 16'h0008) begin n_errors++; $display("FAIL sticky_w1: got %h expected 0008", got_w[1]); end
        n_checks++; if (got_w.size() !== N_WORDS) begin n_errors++; $display("FAIL sticky_len: got %0d expected %0d", got_w.size(), N_WORDS); end
        run_report(0, '0, -1, '0, -1);
        n_checks++; if (got_w[1] !== 16'h0000) begin n_errors++; $display("FAIL sticky_cleared: got %h expected 0000", got_w[1]); end
        // Channel rising in the snapshot cycle itself.
        run_report(0, 8'h40, -1, '0, -1);
        n_checks++; if (got_w[1] !== exp_word(1)) begin n_errors++; $display("FAIL sticky_snap_cycle: got %h expected %h", got_w[1], exp_word(1)); end
    endtask

    task automatic test_late_event();
        run_report(3, '0, 2, 8'h20, -1);
        n_checks++; if (timed_out !== 1'b0) begin n_errors++; $display("FAIL late_timeout: got 1 expected 0"); end
        n_checks++; if (got_w[1][5] !== 1'b0) begin n_errors++; $display("FAIL late_excluded: got w1=%h expected bit5 clear", got_w[1]); end
        n_checks++; if (unstable !== 0) begin n_errors++; $display("FAIL late_stable: got %0d changes expected 0", unstable); end
        run_report(0, '0, -1, '0, -1);
        n_checks++; if (got_w[1] !== 16'h0020) begin n_errors++; $display("FAIL late_next_report: got %h expected 0020", got_w[1]); end
    endtask

    task automatic test_backpressure();
        for (int it = 0; it < 3; it++) begin
            repeat ($urandom_range(1, 6)) drive_cycle(N_CH'($urandom & $urandom), 1'b0, 1'b0);
            run_report(1, '0, -1, '0, -1);
            n_checks++; if (unstable !== 0) begin n_errors++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
            n_checks++; if (got_w.size() !== N_WORDS) begin n_errors++; $display("FAIL bp_len: got %0d expected %0d", got_w.size(), N_WORDS); end
            for (int k = 0; k < got_w.size(); k++) begin
                n_checks++;
                if (got_w[k] !== exp_word(k)) begin n_errors++; $display("FAIL bp_word[%0d]: got %h expected %h", k, got_w[k], exp_word(k)); end
            end
        end
    endtask

    task automatic test_busy_reset();
        int extra;
        run_report(3, '0, -1, '0, 1);
        n_checks++; if (got_w.size() !== N_WORDS) begin n_errors++; $display("FAIL busy_len: got %0d expected %0d", got_w.size(), N_WORDS); end
        extra = 0;
        repeat (10) begin
            if (out_valid || busy) extra++;
            drive_cycle('0, 1'b0, 1'b1);
        end
        n_checks++; if (extra !== 0) begin n_errors++; $display("FAIL busy_dropped_req: got %0d active cycles expected 0", extra); end
        // Abort mid-SEND: outputs clear at once and no clear strobe follows.
        drive_cycle(8'h02, 1'b0, 1'b0);
        drive_cycle('0, 1'b1, 1'b0);
        drive_cycle('0, 1'b0, 1'b0);
        drive_cycle('0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_last, oflow_Clr, busy} !== 4'b0000 || out_data !== 16'h0000) begin
            n_errors++;
            $display("FAIL abort_outputs: got valid=%b last=%b clr=%b busy=%b data=%h, expected all 0",
                     out_valid, out_last, oflow_Clr, busy, out_data);
        end
        model_reset();
        @(negedge clk);
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) rst_n = 1'b1;
            if (oflow_Clr || out_valid) extra++;
            drive_cycle('0, 1'b0, 1'b0);
        end
        n_checks++; if (extra !== 0) begin n_errors++; $display("FAIL abort_no_clear: got %0d active cycles expected 0", extra); end
        run_report(0, '0, -1, '0, -1);
        n_checks++; if (got_w[1] !== 16'h0000) begin n_errors++; $display("FAIL abort_stk_reset: got %h expected 0000", got_w[1]); end
    endtask

`ifdef OFLOW_COUNT_EN
    task automatic test_counters();
        for (int n = 0; n < 300; n++) begin
            drive_cycle(8'h04, 1'b0, 1'b0);
            drive_cycle('0, 1'b0, 1'b0);
        end
        run_report(0, '0, -1, '0, -1);
        n_checks++; if (got_w[4] !== 16'h02FF) begin n_errors++; $display("FAIL cnt_saturate: got %h expected 02ff", got_w[4]); end
        run_report(0, '0, -1, '0, -1);
        n_checks++; if (got_w[4] !== 16'h0200) begin n_errors++; $display("FAIL cnt_cleared: got %h expected 0200", got_w[4]); end
    endtask
`endif

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 20)) drive_cycle(N_CH'($urandom & $urandom), 1'b0, 1'b0);
            run_report(2, N_CH'($urandom & $urandom & $urandom), $urandom_range(0, 15),
                       N_CH'($urandom & $urandom), -1);
            n_checks++; if (timed_out !== 1'b0) begin n_errors++; $display("FAIL rand_timeout[%0d]: got 1 expected 0", it); end
            n_checks++; if (unstable !== 0) begin n_errors++; $display("FAIL rand_stable[%0d]: got %0d expected 0", it, unstable); end
            n_checks++; if (got_w.size() !== N_WORDS) begin n_errors++; $display("FAIL rand_len[%0d]: got %0d expected %0d", it, got_w.size(), N_WORDS); end
            for (int k = 0; k < got_w.size(); k++) begin
                n_checks++;
                if (got_w[k] !== exp_word(k)) begin n_errors++; $display("FAIL rand_word[%0d][%0d]: got %h expected %h", it, k, got_w[k], exp_word(k)); end
                n_checks++;
                if (got_l[k] !== (k == N_WORDS - 1)) begin n_errors++; $display("FAIL rand_last[%0d][%0d]: got %b", it, k, got_l[k]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; oflow_state = '0; rd_req = 1'b0; out_ready = 1'b0;
        model_reset();
        test_reset();
        test_sticky();
        test_late_event();
        test_backpressure();
        test_busy_reset();
`ifdef OFLOW_COUNT_EN
        test_counters();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
